// File: rtl/montgomery_pkg.sv
// Shared widths, word typedefs and an N' helper for the Montgomery reduction pipeline.
package montgomery_pkg;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 4;

  typedef logic [DATA_W-1:0]   word_t;
  typedef logic [2*DATA_W-1:0] dword_t;
  typedef logic [2*DATA_W:0]   sum_t;

  // N' = -N^-1 mod 2^w for odd n. Newton iteration doubles the correct bits each step (3 -> 192).
  function automatic word_t calc_ninv(input word_t n, input int unsigned w);
    word_t x;
    x = n;
    for (int i = 0; i < 6; i++) begin
      x = x * (word_t'(2) - n * x);
    end
    x = word_t'(0) - x;
    if (w < DATA_W) begin
      x = x & ((word_t'(1) << w) - word_t'(1));
    end
    return x;
  endfunction

endpackage

// File: rtl/montgomery_reduce_pipe_shiftreg.sv
// Fixed-depth delay line with a clock enable. No reset: consumers qualify its output with their own valid bits.
module shiftreg #(
  parameter int SHIFT = 2,
  parameter int DATA  = 16
) (
  input  logic            clk,
  input  logic            en,
  input  logic [DATA-1:0] din,
  output logic [DATA-1:0] dout
);

  logic [DATA-1:0] stage_reg [SHIFT];

  always_ff @(posedge clk) begin
    if (en) begin
      stage_reg[0] <= din;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < SHIFT; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (en) begin
          stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign dout = stage_reg[SHIFT-1];

endmodule

// File: rtl/montgomery_reduce_pipe.sv
// Four-stage Montgomery reduction: result = T * 2^-DATA mod MODULUS, one operand per enabled cycle.
// The delay line carries its own enable input, so en_i freezes T together with every other stage.
module montgomery_reduce_pipe
  import montgomery_pkg::*;
#(
  parameter int             DATA     = DATA_W,
  parameter logic [DATA-1:0] MODULUS  = '0,
  parameter logic [DATA-1:0] MOD_NINV = '0,
  parameter int             TAG_W    = montgomery_pkg::TAG_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [2*DATA-1:0] t_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  output logic [DATA-1:0]   result_o,
  output logic [TAG_W-1:0]  tag_o
);

  logic [DATA-1:0]   m1;
  logic [2*DATA-1:0] p2;
  logic [DATA:0]     t3;
  logic              v1, v2, v3;
  logic [TAG_W-1:0]  tag1, tag2, tag3;

  logic [2*DATA-1:0] t_dly;
  logic [2*DATA-1:0] prod_m;
  logic [2*DATA-1:0] prod_p;
  logic [2*DATA:0]   sum_s;
  logic [DATA:0]     res_full;
  logic              unused_bits;

  // T is consumed at stage 3, two enabled edges after it enters.
  shiftreg #(
    .SHIFT(2),
    .DATA (2*DATA)
  ) u_t_delay (
    .clk (clk_i),
    .en  (en_i),
    .din (t_i),
    .dout(t_dly)
  );

  assign prod_m   = {{DATA{1'b0}}, t_i[DATA-1:0]} * {{DATA{1'b0}}, MOD_NINV};
  assign prod_p   = {{DATA{1'b0}}, m1} * {{DATA{1'b0}}, MODULUS};
  assign sum_s    = {1'b0, t_dly} + {1'b0, p2};
  assign res_full = (t3 >= {1'b0, MODULUS}) ? (t3 - {1'b0, MODULUS}) : t3;

  // Low half of the sum is zero by construction; t3 < 2N leaves the top bit of res_full clear.
  assign unused_bits = ^{prod_m[2*DATA-1:DATA], sum_s[DATA-1:0], res_full[DATA]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m1       <= '0;
      p2       <= '0;
      t3       <= '0;
      result_o <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      valid_o  <= 1'b0;
      tag1     <= '0;
      tag2     <= '0;
      tag3     <= '0;
      tag_o    <= '0;
    end else if (en_i) begin
      m1       <= prod_m[DATA-1:0];
      p2       <= prod_p;
      t3       <= sum_s[2*DATA:DATA];
      result_o <= res_full[DATA-1:0];
      v1       <= valid_i;
      v2       <= v1;
      v3       <= v2;
      valid_o  <= v3;
      tag1     <= tag_i;
      tag2     <= tag1;
      tag3     <= tag2;
      tag_o    <= tag3;
    end
  end

endmodule

// File: tb/tb_montgomery_reduce_pipe.sv
// Scoreboard bench: driver queues expected REDC results, a monitor pops them as valid_o fires.
module tb_montgomery_reduce_pipe;

  localparam int DATA = 8;
  localparam int NMOD = 13;
  localparam int RVAL = 256;
  localparam int TAGW = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              en_i = 1'b0;
  logic              valid_i = 1'b0;
  logic [2*DATA-1:0] t_i = '0;
  logic [TAGW-1:0]   tag_i = '0;
  logic              valid_o;
  logic [DATA-1:0]   result_o;
  logic [TAGW-1:0]   tag_o;

  montgomery_reduce_pipe #(
    .DATA    (DATA),
    .MODULUS (8'd13),
    .MOD_NINV(8'd59),
    .TAG_W   (TAGW)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (en_i),
    .valid_i (valid_i),
    .t_i     (t_i),
    .tag_i   (tag_i),
    .valid_o (valid_o),
    .result_o(result_o),
    .tag_o   (tag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned res;
    int unsigned tag;
    int          due;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   ecnt = 0;
  int   rinv = 0;

  // Reference: T * R^-1 mod N, with R^-1 found by search.
  function automatic int unsigned ref_redc(input int unsigned t);
    return ((t % NMOD) * rinv) % NMOD;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic v, input int unsigned t, input int unsigned tag, input logic en);
    @(negedge clk_i);
    valid_i = v;
    t_i     = t[2*DATA-1:0];
    tag_i   = tag[TAGW-1:0];
    en_i    = en;
    if (en && v && rst_ni) begin
      q.push_back('{res: ref_redc(t), tag: tag, due: ecnt + 4});
      $display("issue t=%0d tag=%0d expect=%0d", t, tag, ref_redc(t));
    end
  endtask

  // Monitor
  initial begin
    logic en_s, rst_s, prev_ok;
    logic [DATA+TAGW:0] prev;
    exp_t e;
    prev_ok = 1'b0;
    prev = '0;
    forever begin
      @(posedge clk_i);
      en_s  = en_i;
      rst_s = rst_ni;
      if (rst_s && en_s) ecnt++;
      #1;
      if (!rst_ni || !rst_s) begin
        prev_ok = 1'b0;
      end else begin
        if (en_s) begin
          if (valid_o) begin
            if (q.size() == 0) begin
              check("unexpected_valid", 1, 0);
            end else begin
              e = q.pop_front();
              $display("result=%0d tag=%0d edge=%0d (exp %0d/%0d/%0d)",
                       result_o, tag_o, ecnt, e.res, e.tag, e.due);
              check("result", result_o, e.res);
              check("tag", tag_o, e.tag);
              check("latency_edge", ecnt, e.due);
            end
          end else if (q.size() > 0 && q[0].due <= ecnt) begin
            check("missing_valid", 0, 1);
            void'(q.pop_front());
          end
        end else if (prev_ok) begin
          check("hold", {valid_o, result_o, tag_o}, prev);
        end
        prev = {valid_o, result_o, tag_o};
        prev_ok = 1'b1;
      end
    end
  end

  initial begin
    int unsigned tv;
    for (int x = 0; x < NMOD; x++) if ((x * RVAL) % NMOD == 1) rinv = x;

    // Reset held for 3 cycles
    rst_ni = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("reset_valid", valid_o, 0);
      check("reset_result", result_o, 0);
      check("reset_tag", tag_o, 0);
    end
    rst_ni = 1'b1;

    // Zero, basic, max operand
    drive(1, 0, 0, 1);
    drive(1, 1, 5, 1);
    drive(1, 3327, 7, 1);
    repeat (5) drive(0, 0, 0, 1);

    // Streaming with a bubble
    drive(1, 1, 1, 1);
    drive(1, 3327, 2, 1);
    drive(1, 0, 3, 1);
    drive(0, 0, 0, 1);
    drive(1, 1, 4, 1);
    repeat (5) drive(0, 0, 0, 1);

    // Stall with 3 in flight
    drive(1, 100, 6, 1);
    drive(1, 2000, 7, 1);
    drive(1, 3000, 8, 1);
    repeat (5) drive(1, 55, 9, 0);
    repeat (6) drive(0, 0, 0, 1);

    // Reset mid-flight
    drive(1, 17, 1, 1);
    drive(1, 29, 2, 1);
    drive(1, 31, 3, 1);
    drive(1, 45, 4, 1);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    q.delete();
    #1;
    check("midreset_valid", valid_o, 0);
    check("midreset_result", result_o, 0);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (6) drive(0, 0, 0, 1);
    drive(1, 2, 10, 1);

    // Random run
    for (int i = 0; i < 1000; i++) begin
      tv = $urandom_range(3327, 0);
      drive(1, tv, $urandom_range(15, 0), ($urandom_range(9, 0) != 0));
      if ($urandom_range(4, 0) == 0) drive(0, 0, 0, ($urandom_range(9, 0) != 0));
    end

    // Drain, bounded
    for (int i = 0; i < 20 && q.size() > 0; i++) drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    check("leftover_expected", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
